mesi_isc_snoop_sched: RTL and testbench

Broadcast scheduler for the MESI intersection controller's coherence bus. Arbitrates round-robin among four cores' main-bus broadcast requests (WR_BROAD / RD_BROAD). Sequences one transaction at a time: snoop every other core, collect their acks, then enable the requester. Sits between the mbus inputs and cbus outputs of the ISC top level and is the only driver of cbus_cmd*_o and cbus_addr_o.

---
 rtl/mesi_isc_snoop_sched.sv | 210 +++++++++++++++++++++
 tb/tb_mesi_isc_snoop_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_snoop_sched.sv
// mesi_isc_snoop_sched
//   Broadcast scheduler for the MESI intersection controller coherence bus.
//   It arbitrates round-robin among the WR_BROAD/RD_BROAD requests of four cores.
//   It handles one transaction at a time: the winner is acked, every other core
//   is snooped until it acks, and then the winner is enabled.
//
// Ports
//   clk                          clock, rising edge
//   rst                          asynchronous active-low reset
//   mbus_cmd{3..0}_i   [2:0]     main-bus command per core (3=WR_BROAD, 4=RD_BROAD)
//   mbus_addr{3..0}_i  [AW-1:0]  main-bus address per core
//   cbus_ack{3..0}_i             coherence-bus ack per core
//   cbus_addr_o        [AW-1:0]  address of the current/last transaction
//   cbus_cmd{3..0}_o   [2:0]     coherence command per core
//   mbus_ack{3..0}_o             one-cycle grant pulse per core
//   err_o                        sticky snoop-timeout flag
module mesi_isc_snoop_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mbus_cmd3_i,
    input  logic [2:0]            mbus_cmd2_i,
    input  logic [2:0]            mbus_cmd1_i,
    input  logic [2:0]            mbus_cmd0_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr3_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr2_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr1_i,
    input  logic [ADDR_WIDTH-1:0] mbus_addr0_i,
    input  logic                  cbus_ack3_i,
    input  logic                  cbus_ack2_i,
    input  logic                  cbus_ack1_i,
    input  logic                  cbus_ack0_i,
    output logic [ADDR_WIDTH-1:0] cbus_addr_o,
    output logic [2:0]            cbus_cmd3_o,
    output logic [2:0]            cbus_cmd2_o,
    output logic [2:0]            cbus_cmd1_o,
    output logic [2:0]            cbus_cmd0_o,
    output logic                  mbus_ack3_o,
    output logic                  mbus_ack2_o,
    output logic                  mbus_ack1_o,
    output logic                  mbus_ack0_o,
    output logic                  err_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_SNOOP  = 2'd2;
    localparam logic [1:0] ST_ENABLE = 2'd3;

    localparam logic [2:0] MB_WR_BROAD = 3'd3;
    localparam logic [2:0] MB_RD_BROAD = 3'd4;

    localparam logic [2:0] CB_NOP      = 3'd0;
    localparam logic [2:0] CB_WR_SNOOP = 3'd1;
    localparam logic [2:0] CB_RD_SNOOP = 3'd2;
    localparam logic [2:0] CB_EN_WR    = 3'd3;
    localparam logic [2:0] CB_EN_RD    = 3'd4;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [3:0][2:0]            mcmd;
    logic [3:0][ADDR_WIDTH-1:0] maddr;
    logic [3:0]                 cack;
    logic [3:0]                 req;

    assign mcmd  = {mbus_cmd3_i, mbus_cmd2_i, mbus_cmd1_i, mbus_cmd0_i};
    assign maddr = {mbus_addr3_i, mbus_addr2_i, mbus_addr1_i, mbus_addr0_i};
    assign cack  = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            req[k] = (mcmd[k] == MB_WR_BROAD) || (mcmd[k] == MB_RD_BROAD);
        end
    end

    logic [1:0]            state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  wr_q, wr_d;
    logic [3:0]            mask_q, mask_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0][2:0]       cmd_q, cmd_d;
    logic [3:0]            ack_q, ack_d;

    // Round-robin search starting at the pointer.
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;

    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    gnt_d   = win;
                    wr_d    = (mcmd[win] == MB_WR_BROAD);
                    addr_d  = maddr[win];
                    ptr_d   = win + 2'd1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                mask_d  = ~(4'b0001 << gnt_q);
                cnt_d   = '0;
                state_d = ST_SNOOP;
            end
            ST_SNOOP: begin
                mask_d = mask_q & ~cack;
                cnt_d  = cnt_q + 16'd1;
                if (mask_d == '0) begin
                    state_d = ST_ENABLE;
                end else if (cnt_q == CNT_LAST) begin
                    mask_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_ENABLE;
                end
            end
            default: begin
                if (cack[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs are registered from the next-state values, so a command change
    // caused by an ack at edge M is visible right after edge M.
    always_comb begin
        cmd_d = '0;
        ack_d = '0;
        if (state_q == ST_IDLE && found) begin
            ack_d[win] = 1'b1;
        end
        if (state_d == ST_SNOOP) begin
            for (int unsigned j = 0; j < 4; j++) begin
                if (mask_d[j]) begin
                    cmd_d[j] = wr_d ? CB_WR_SNOOP : CB_RD_SNOOP;
                end
            end
        end else if (state_d == ST_ENABLE) begin
            cmd_d[gnt_d] = wr_d ? CB_EN_WR : CB_EN_RD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            wr_q    <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            cmd_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            ack_q   <= ack_d;
        end
    end

    assign cbus_addr_o = addr_q;
    assign cbus_cmd3_o = cmd_q[3];
    assign cbus_cmd2_o = cmd_q[2];
    assign cbus_cmd1_o = cmd_q[1];
    assign cbus_cmd0_o = cmd_q[0];
    assign mbus_ack3_o = ack_q[3];
    assign mbus_ack2_o = ack_q[2];
    assign mbus_ack1_o = ack_q[1];
    assign mbus_ack0_o = ack_q[0];
    assign err_o       = err_q;

    // CB_NOP is the all-zero default of cmd_d.
    logic unused_nop;
    assign unused_nop = ^CB_NOP;

endmodule

// File: tb/tb_mesi_isc_snoop_sched.sv
// Directed bench for mesi_isc_snoop_sched. Expected grants (port, address) are
// queued when requests are driven and matched by a monitor whenever an
// mbus_ack pulse appears; cycle-level command patterns are checked inline.
module tb_mesi_isc_snoop_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  mcmd  [4];
    logic [31:0] maddr [4];
    logic [3:0]  cack;
    logic [31:0] addr;
    logic [2:0]  c3, c2, c1, c0;
    logic        a3, a2, a1, a0;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    mesi_isc_snoop_sched #(.TIMEOUT_CYCLES(8), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mbus_cmd3_i(mcmd[3]), .mbus_cmd2_i(mcmd[2]),
        .mbus_cmd1_i(mcmd[1]), .mbus_cmd0_i(mcmd[0]),
        .mbus_addr3_i(maddr[3]), .mbus_addr2_i(maddr[2]),
        .mbus_addr1_i(maddr[1]), .mbus_addr0_i(maddr[0]),
        .cbus_ack3_i(cack[3]), .cbus_ack2_i(cack[2]),
        .cbus_ack1_i(cack[1]), .cbus_ack0_i(cack[0]),
        .cbus_addr_o(addr),
        .cbus_cmd3_o(c3), .cbus_cmd2_o(c2), .cbus_cmd1_o(c1), .cbus_cmd0_o(c0),
        .mbus_ack3_o(a3), .mbus_ack2_o(a2), .mbus_ack1_o(a1), .mbus_ack0_o(a0),
        .err_o(err)
    );

    function automatic logic [11:0] cmds();
        return {c3, c2, c1, c0};
    endfunction

    function automatic logic [3:0] macks();
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [11:0] snoop_pat(input int g, input logic [2:0] code);
        logic [11:0] p = '0;
        for (int j = 0; j < 4; j++) if (j != g) p[3*j +: 3] = code;
        return p;
    endfunction

    function automatic logic [11:0] en_pat(input int g, input logic [2:0] code);
        logic [11:0] p = '0;
        p[3*g +: 3] = code;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every grant pulse must match the head of the queue.
    always @(negedge clk) begin
        if (macks() != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {28'd0, macks()}, 32'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("sb_ack", {28'd0, macks()}, {28'd0, 4'(4'b0001 << e[33:32])});
                check("sb_addr", addr, e[31:0]);
            end
        end
    end

    task automatic wait_grant(output int g);
        bit seen = 0;
        g = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            step();
            if (macks() != 4'b0000) seen = 1;
        end
        check("grant_wait", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 4; k++) if (macks()[k]) g = k;
    endtask

    // Runs snoop/enable with every ack on the first opportunity; entered in GRANT.
    task automatic do_txn(input int g, input logic [2:0] sn, input logic [2:0] en);
        step();
        check("txn_snoop", {20'd0, cmds()}, {20'd0, snoop_pat(g, sn)});
        cack = ~(4'(4'b0001 << g));
        step();
        check("txn_enable", {20'd0, cmds()}, {20'd0, en_pat(g, en)});
        cack = 4'(4'b0001 << g);
        step();
        check("txn_idle", {20'd0, cmds()}, 32'd0);
        cack = '0;
    endtask

    initial begin
        int g;
        for (int k = 0; k < 4; k++) begin
            mcmd[k]  = '0;
            maddr[k] = '0;
        end
        cack = '0;

        // Reset state
        repeat (3) step();
        check("rst_cmds", {20'd0, cmds()}, 32'd0);
        check("rst_acks", {28'd0, macks()}, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        step();

        // Single request, immediate acks
        mcmd[2] = 3'd3; maddr[2] = 32'h1000;
        exp_q.push_back({2'd2, 32'h1000});
        step();
        check("t1_ack", {28'd0, macks()}, 32'h4);
        check("t1_addr", addr, 32'h1000);
        check("t1_grant_cmds", {20'd0, cmds()}, 32'd0);
        mcmd[2] = 3'd0;
        step();
        check("t1_ack_drop", {28'd0, macks()}, 32'd0);
        check("t1_snoop", {20'd0, cmds()}, {20'd0, snoop_pat(2, 3'd1)});
        cack = 4'b1011;
        step();
        check("t1_enable", {20'd0, cmds()}, {20'd0, en_pat(2, 3'd3)});
        cack = 4'b0100;
        step();
        check("t1_done", {20'd0, cmds()}, 32'd0);
        check("t1_addr_hold", addr, 32'h1000);
        cack = '0;

        // Staggered acks, RD_BROAD from core 0
        mcmd[0] = 3'd4; maddr[0] = 32'h2000;
        exp_q.push_back({2'd0, 32'h2000});
        step();
        mcmd[0] = 3'd0;
        step();
        check("t2_snoop", {20'd0, cmds()}, {20'd0, snoop_pat(0, 3'd2)});
        cack = 4'b0010;
        step();
        check("t2_ack1", {20'd0, cmds()}, 32'b010_010_000_000);
        cack = 4'b0100;
        step();
        check("t2_ack2", {20'd0, cmds()}, 32'b010_000_000_000);
        cack = 4'b1000;
        step();
        check("t2_enable", {20'd0, cmds()}, {20'd0, en_pat(0, 3'd4)});
        cack = 4'b1110;  // spurious acks from non-requesters
        step();
        check("t2_spurious", {20'd0, cmds()}, {20'd0, en_pat(0, 3'd4)});
        cack = 4'b0001;
        step();
        check("t2_done", {20'd0, cmds()}, 32'd0);
        cack = '0;

        // Ignored commands and spurious acks while idle
        mcmd[0] = 3'd1; mcmd[1] = 3'd2; mcmd[2] = 3'd5; mcmd[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cack = ~cack;
            step();
            check("ign_acks", {28'd0, macks()}, 32'd0);
            check("ign_cmds", {20'd0, cmds()}, 32'd0);
        end
        check("ign_addr", addr, 32'h2000);
        for (int k = 0; k < 4; k++) mcmd[k] = 3'd0;
        cack = '0;

        // Round-robin from reset, all cores requesting continuously
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mcmd[k]  = 3'd3;
            maddr[k] = 32'h100 + k;
        end
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 32'h100 + k});
        exp_q.push_back({2'd0, 32'h100});
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            check("rr_order", g, i % 4);
            if (i == 4) for (int k = 0; k < 4; k++) mcmd[k] = 3'd0;
            do_txn(g, 3'd1, 3'd3);
        end

        // Timeout: core 3 never acks
        mcmd[1] = 3'd3; maddr[1] = 32'hABC;
        exp_q.push_back({2'd1, 32'hABC});
        wait_grant(g);
        mcmd[1] = 3'd0;
        step();  // SNOOP entry edge
        check("to_snoop", {20'd0, cmds()}, {20'd0, snoop_pat(1, 3'd1)});
        cack = 4'b0101;
        step();
        check("to_pending3", {20'd0, cmds()}, 32'b001_000_000_000);
        cack = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("to_err_low", {31'd0, err}, 32'd0);
            check("to_wait_cmds", {20'd0, cmds()}, 32'b001_000_000_000);
        end
        step();  // 8 edges after SNOOP entry
        check("to_err_rise", {31'd0, err}, 32'd1);
        check("to_enable", {20'd0, cmds()}, {20'd0, en_pat(1, 3'd3)});
        cack = 4'b0010;
        step();
        check("to_done", {20'd0, cmds()}, 32'd0);
        cack = '0;
        step();
        check("to_err_sticky", {31'd0, err}, 32'd1);

        // Reset mid-SNOOP
        mcmd[2] = 3'd3; maddr[2] = 32'h55;
        exp_q.push_back({2'd2, 32'h55});
        wait_grant(g);
        mcmd[2] = 3'd0;
        step();
        check("mr_snoop", {20'd0, cmds()}, {20'd0, snoop_pat(2, 3'd1)});
        #2 rst = 1'b0;
        #1;
        check("mr_cmds", {20'd0, cmds()}, 32'd0);
        check("mr_acks", {28'd0, macks()}, 32'd0);
        check("mr_addr", addr, 32'd0);
        check("mr_err", {31'd0, err}, 32'd0);
        step();
        rst = 1'b1;
        mcmd[1] = 3'd3; maddr[1] = 32'h11;
        mcmd[3] = 3'd3; maddr[3] = 32'h33;
        exp_q.push_back({2'd1, 32'h11});
        exp_q.push_back({2'd3, 32'h33});
        wait_grant(g);
        check("mr_ptr0", g, 1);
        mcmd[1] = 3'd0;
        do_txn(1, 3'd1, 3'd3);
        wait_grant(g);
        check("mr_second", g, 3);
        mcmd[3] = 3'd0;
        do_txn(3, 3'd1, 3'd3);

        step();
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
